ram_block_reader: RTL and testbench

- Reader side of the start-and-compute flow used with the lab embedded memories.
- On a rising edge of a start level, sequentially reads NUM_WORDS words from a synchronous single-port RAM, addresses 0..NUM_WORDS-1, with 1-cycle read latency.
- Accumulates sum, maximum and minimum, then raises a sticky done flag.
- Sits beside the RAM-writing experiment logic; a switch drives the start input and the results drive the LEDs and seven-segment displays.

---
 rtl/ram_block_reader.sv | 146 ++++++++++++++
 tb/tb_ram_block_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_reader.sv
// Start-triggered sequential reader for a synchronous single-port RAM.
// Walks addresses 0..NUM_WORDS-1 and accumulates sum, max and min, then holds a sticky done flag.
module ram_block_reader #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 512
) (
    input  logic                     CLOCK_50_I,
    input  logic                     RESET_I,
    input  logic                     START_I,
    output logic [ADDR_W-1:0]        ADDRESS_O,
    input  logic [DATA_W-1:0]        READ_DATA_I,
    output logic                     BUSY_O,
    output logic                     DONE_O,
    output logic [DATA_W+ADDR_W-1:0] SUM_O,
    output logic [DATA_W-1:0]        MAX_O,
    output logic [DATA_W-1:0]        MIN_O
);

    localparam int                SUM_W     = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              start_q;
    logic              start_edge;
    logic              issue_q;
    logic              ram_valid_q;
    logic              at_last;

    logic              launch;
    logic              advance;
    logic              finish;

    logic [ADDR_W-1:0] addr_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [SUM_W-1:0]  sum_reg;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] min_reg;

    assign start_edge = START_I & ~start_q;
    assign at_last    = (addr_reg == LAST_ADDR);

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_edge) state_next = S_READ;
            S_READ:  if (at_last) state_next = S_DRAIN;
            S_DRAIN: if (ram_valid_q && !issue_q) state_next = S_DONE;
            S_DONE:  if (start_edge) state_next = S_READ;
            default: state_next = S_IDLE;
        endcase
    end

    // Control strobes; start edges are only honoured while no run is active.
    always_comb begin
        launch  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_reg)
            S_IDLE:  launch  = start_edge;
            S_READ:  advance = !at_last;
            S_DRAIN: finish  = ram_valid_q && !issue_q;
            S_DONE:  launch  = start_edge;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            start_q <= 1'b0;
        end else begin
            start_q <= START_I;
        end
    end

    // issue_q: ADDRESS_O holds a fresh address; ram_valid_q: READ_DATA_I carries its word.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            issue_q     <= 1'b0;
            ram_valid_q <= 1'b0;
        end else begin
            issue_q     <= launch | advance;
            ram_valid_q <= issue_q;
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            addr_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (launch) begin
            addr_reg <= '0;
            busy_reg <= 1'b1;
            done_reg <= 1'b0;
        end else if (advance) begin
            addr_reg <= addr_reg + 1'b1;
        end else if (finish) begin
            addr_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            sum_reg <= '0;
            max_reg <= '0;
            min_reg <= '1;
        end else if (launch) begin
            sum_reg <= '0;
            max_reg <= '0;
            min_reg <= '1;
        end else if (ram_valid_q) begin
            sum_reg <= sum_reg + SUM_W'(READ_DATA_I);
            if (READ_DATA_I > max_reg) max_reg <= READ_DATA_I;
            if (READ_DATA_I < min_reg) min_reg <= READ_DATA_I;
        end
    end

    assign ADDRESS_O = addr_reg;
    assign BUSY_O    = busy_reg;
    assign DONE_O    = done_reg;
    assign SUM_O     = sum_reg;
    assign MAX_O     = max_reg;
    assign MIN_O     = min_reg;

endmodule

// File: tb/tb_ram_block_reader.sv
// Scoreboard bench for ram_block_reader: a 512-word instance and a single-word instance,
// each fed by a 1-cycle-latency RAM model.
module tb_ram_block_reader;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int SW = DW + AW;
    localparam int N0 = 512;
    localparam int N1 = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] rd0, rd1;
    logic          busy0, busy1, done0, done1;
    logic [SW-1:0] sum0, sum1;
    logic [DW-1:0] max0, min0, max1, min1;

    logic [DW-1:0] mem0 [N0];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    logic d0_prev = 1'b0;
    logic d1_prev = 1'b0;

    typedef struct {
        logic [SW-1:0] sum;
        logic [DW-1:0] mx;
        logic [DW-1:0] mn;
        int            due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd0 <= mem0[addr0];
        rd1 <= (addr1 == '0) ? 8'h3C : 8'h00;
    end

    ram_block_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N0)) u0 (
        .CLOCK_50_I (clk),
        .RESET_I    (rst),
        .START_I    (start0),
        .ADDRESS_O  (addr0),
        .READ_DATA_I(rd0),
        .BUSY_O     (busy0),
        .DONE_O     (done0),
        .SUM_O      (sum0),
        .MAX_O      (max0),
        .MIN_O      (min0)
    );

    ram_block_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N1)) u1 (
        .CLOCK_50_I (clk),
        .RESET_I    (rst),
        .START_I    (start1),
        .ADDRESS_O  (addr1),
        .READ_DATA_I(rd1),
        .BUSY_O     (busy1),
        .DONE_O     (done1),
        .SUM_O      (sum1),
        .MAX_O      (max1),
        .MIN_O      (min1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_addr"}, 64'(addr0), 64'(0));
        chk({tag, "_busy"}, 64'(busy0), 64'(0));
        chk({tag, "_done"}, 64'(done0), 64'(0));
        chk({tag, "_sum"},  64'(sum0),  64'(0));
        chk({tag, "_max"},  64'(max0),  64'(0));
        chk({tag, "_min"},  64'(min0),  64'(8'hFF));
    endtask

    // Monitor: on each DONE rising edge pop the oldest expectation and compare.
    task automatic check_rise(input int u);
        exp_t e;
        if (u == 0) begin
            if (sb0.size() == 0) begin
                chk("u0_unexpected_done", 64'(1), 64'(0));
            end else begin
                e = sb0.pop_front();
                chk("u0_sum", 64'(sum0), 64'(e.sum));
                chk("u0_max", 64'(max0), 64'(e.mx));
                chk("u0_min", 64'(min0), 64'(e.mn));
                chk("u0_done_cycle", 64'(cyc), 64'(e.due));
            end
        end else begin
            if (sb1.size() == 0) begin
                chk("u1_unexpected_done", 64'(1), 64'(0));
            end else begin
                e = sb1.pop_front();
                chk("u1_sum", 64'(sum1), 64'(e.sum));
                chk("u1_max", 64'(max1), 64'(e.mx));
                chk("u1_min", 64'(min1), 64'(e.mn));
                chk("u1_done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done0 && !d0_prev) check_rise(0);
            if (done1 && !d1_prev) check_rise(1);
            d0_prev = done0;
            d1_prev = done1;
        end
    end

    // One run on u0 from the current negedge; checks address stepping and busy length.
    task automatic track_run(input logic [SW-1:0] es, input logic [DW-1:0] emx,
                             input logic [DW-1:0] emn, input int abort_at,
                             input int reraise_at, input bit via_reset);
        exp_t e;
        int   addr_err = 0;
        int   busy_n   = 0;
        int   exp_a;
        e.sum = es;
        e.mx  = emx;
        e.mn  = emn;
        e.due = cyc + 1 + N0 + 1;
        sb0.push_back(e);
        if (via_reset) rst = 1'b0;
        else start0 = 1'b1;
        for (int i = 0; i <= N0 + 1; i++) begin
            @(negedge clk);
            exp_a = (i < N0) ? i : ((i == N0) ? N0 - 1 : 0);
            if (addr0 !== AW'(exp_a)) addr_err++;
            if (busy0) busy_n++;
            if (i == 0) begin
                chk("launch_done_clear", 64'(done0), 64'(0));
                chk("launch_sum_clear",  64'(sum0),  64'(0));
                chk("launch_min_set",    64'(min0),  64'(8'hFF));
            end
            if (i == 2) start0 = 1'b0;
            if (reraise_at >= 0 && i == reraise_at - 1) start0 = 1'b1;
            if (reraise_at >= 0 && i == reraise_at + 2) start0 = 1'b0;
            if (i == abort_at) begin
                void'(sb0.pop_back());
                start0 = 1'b1;
                #2 rst = 1'b1;
                #1 chk_reset0("async_reset");
                break;
            end
        end
        chk("addr_seq_errs", 64'(addr_err), 64'(0));
        chk("busy_cycles", 64'(busy_n), 64'((abort_at >= 0) ? abort_at + 1 : N0 + 1));
    endtask

    initial begin
        int busy_n;
        int addr_err;
        exp_t e;

        #1 rst = 1'b1;
        #1 chk_reset0("por");
        chk("por_u1_min", 64'(min1), 64'(8'hFF));
        chk("por_u1_done", 64'(done1), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp: 2 * (0+..+255) = 65280
        for (int k = 0; k < N0; k++) mem0[k] = 8'(k);
        track_run(SW'(65280), 8'd255, 8'd0, -1, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("done_sticky", 64'(done0), 64'(1));

        // All ones: 512 * 255 = 130560
        for (int k = 0; k < N0; k++) mem0[k] = 8'hFF;
        track_run(SW'(130560), 8'd255, 8'd255, -1, -1, 1'b0);

        // All A5 with a second start edge mid-run: 512 * 165 = 84480
        for (int k = 0; k < N0; k++) mem0[k] = 8'hA5;
        track_run(SW'(84480), 8'd165, 8'd165, -1, 100, 1'b0);

        // Reset at E+200 with START_I high; release launches exactly one new run
        track_run(SW'(84480), 8'd165, 8'd165, 200, -1, 1'b0);
        repeat (3) @(negedge clk);
        track_run(SW'(84480), 8'd165, 8'd165, -1, -1, 1'b1);

        // Back-to-back: (k*3) mod 256 permutes 0..255 twice over 512 words -> 65280
        for (int k = 0; k < N0; k++) mem0[k] = 8'(k * 3);
        track_run(SW'(65280), 8'd255, 8'd0, -1, -1, 1'b0);

        // Reset with START_I low: stays idle
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", 64'(busy0), 64'(0));
        chk("idle_done", 64'(done0), 64'(0));
        chk("idle_addr", 64'(addr0), 64'(0));

        // Single-word instance: mem[0]=0x3C -> 60
        e.sum = SW'(60);
        e.mx  = 8'h3C;
        e.mn  = 8'h3C;
        e.due = cyc + 1 + N1 + 1;
        sb1.push_back(e);
        start1   = 1'b1;
        busy_n   = 0;
        addr_err = 0;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (addr1 !== '0) addr_err++;
            if (busy1) busy_n++;
        end
        start1 = 1'b0;
        chk("u1_addr_errs", 64'(addr_err), 64'(0));
        chk("u1_busy_cycles", 64'(busy_n), 64'(N1 + 1));
        repeat (2) @(negedge clk);

        chk("u0_pending_runs", 64'(sb0.size()), 64'(0));
        chk("u1_pending_runs", 64'(sb1.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
